bypass_history_net: RTL

//   Multi-port operand bypass network with a registered writeback history.
//   It captures W writeback ports per cycle into an S-deep shift history. It serves R read

---
 rtl/bypass_history_net.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bypass_history_net.sv
// rtl/bypass_history_net.sv - multi-port operand bypass network with registered writeback history
//
// Purpose:
//   Captures WBPORTS writeback ports each cycle into a STAGES-deep shift history
//   and serves RDPORTS combinational lookups. Each lookup returns the youngest
//   matching value. Level 0 is the live writeback bus, and level k is the
//   writeback set captured k shifting edges ago.
//
// Ports:
//   clk              clock, all state on posedge
//   rst              synchronous reset, active-low (0 = reset)
//   i_wb_vld         writeback valid per port                 [WBPORTS]
//   i_wb_idx         writeback register index per port        [WBPORTS][IDXWIDTH]
//   i_wb_data        writeback data per port                  [WBPORTS][DWIDTH]
//   i_hold           freeze history (no shift, no capture)
//   i_flush          invalidate all history levels (overrides hold)
//   i_rd_idx         lookup index per read port               [RDPORTS][IDXWIDTH]
//   o_rd_hit         match found at some level                [RDPORTS]
//   o_rd_data        bypassed data, 0 on miss                 [RDPORTS][DWIDTH]
//   o_rd_level       level of the hit, 0 = current cycle      [RDPORTS][LVLW]
//   o_multi_hit_err  sticky duplicate-valid-index-within-a-level flag
module bypass_history_net #(
  parameter int WBPORTS  = 4,
  parameter int STAGES   = 2,
  parameter int RDPORTS  = 2,
  parameter int IDXWIDTH = 7,
  parameter int DWIDTH   = 64,
  localparam int LVLW    = $clog2(STAGES + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WBPORTS-1:0]                 i_wb_vld,
  input  logic [WBPORTS-1:0][IDXWIDTH-1:0]   i_wb_idx,
  input  logic [WBPORTS-1:0][DWIDTH-1:0]     i_wb_data,
  input  logic                               i_hold,
  input  logic                               i_flush,
  input  logic [RDPORTS-1:0][IDXWIDTH-1:0]   i_rd_idx,
  output logic [RDPORTS-1:0]                 o_rd_hit,
  output logic [RDPORTS-1:0][DWIDTH-1:0]     o_rd_data,
  output logic [RDPORTS-1:0][LVLW-1:0]       o_rd_level,
  output logic                               o_multi_hit_err
);

  // History storage: entry [0] is level 1 and entry [STAGES-1] is level STAGES.
  logic [STAGES-1:0][WBPORTS-1:0]                 r_hist_vld;
  logic [STAGES-1:0][WBPORTS-1:0][IDXWIDTH-1:0]   r_hist_idx;
  logic [STAGES-1:0][WBPORTS-1:0][DWIDTH-1:0]     r_hist_data;
  logic                                           r_err;

  // Unified view of all levels. Level 0 is the live bus.
  logic [STAGES:0][WBPORTS-1:0]                   w_lvl_vld;
  logic [STAGES:0][WBPORTS-1:0][IDXWIDTH-1:0]     w_lvl_idx;
  logic [STAGES:0][WBPORTS-1:0][DWIDTH-1:0]       w_lvl_data;

  logic                                           w_shift;
  logic                                           w_dup;
  logic [RDPORTS-1:0]                             w_hit;
  logic [RDPORTS-1:0][DWIDTH-1:0]                 w_data;
  logic [RDPORTS-1:0][LVLW-1:0]                   w_level;

  assign w_lvl_vld  = {r_hist_vld,  i_wb_vld};
  assign w_lvl_idx  = {r_hist_idx,  i_wb_idx};
  assign w_lvl_data = {r_hist_data, i_wb_data};

  assign w_shift = !i_hold && !i_flush;

  // Valid bits and the sticky error are the only state that needs reset.
  // A flush clears the valid bits even while held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hist_vld <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= r_err | w_dup;
      if (i_flush) begin
        r_hist_vld <= '0;
      end else if (!i_hold) begin
        r_hist_vld[0] <= i_wb_vld;
        for (int k = 1; k < STAGES; k++) begin
          r_hist_vld[k] <= r_hist_vld[k-1];
        end
      end
    end
  end

  // Payload moves in lockstep with the valid bits. Its contents are
  // meaningless whenever the matching valid bit is clear, so it has no reset.
  always_ff @(posedge clk) begin
    if (rst && w_shift) begin
      r_hist_idx[0]  <= i_wb_idx;
      r_hist_data[0] <= i_wb_data;
      for (int k = 1; k < STAGES; k++) begin
        r_hist_idx[k]  <= r_hist_idx[k-1];
        r_hist_data[k] <= r_hist_data[k-1];
      end
    end
  end

  // Duplicate detection runs independently per level.
  // The same index at different levels is legal.
  always_comb begin
    w_dup = 1'b0;
    for (int l = 0; l <= STAGES; l++) begin
      for (int i = 0; i < WBPORTS; i++) begin
        for (int j = i + 1; j < WBPORTS; j++) begin
          if (w_lvl_vld[l][i] && w_lvl_vld[l][j] &&
              (w_lvl_idx[l][i] == w_lvl_idx[l][j])) begin
            w_dup = 1'b1;
          end
        end
      end
    end
  end

  // Priority scan: youngest level first, then lowest slot within that level.
  // The first match latches, and later matches are ignored.
  always_comb begin
    w_hit   = '0;
    w_data  = '0;
    w_level = '0;
    for (int r = 0; r < RDPORTS; r++) begin
      for (int l = 0; l <= STAGES; l++) begin
        for (int s = 0; s < WBPORTS; s++) begin
          if (!w_hit[r] && w_lvl_vld[l][s] && (w_lvl_idx[l][s] == i_rd_idx[r])) begin
            w_hit[r]   = 1'b1;
            w_data[r]  = w_lvl_data[l][s];
            w_level[r] = LVLW'(l);
          end
        end
      end
    end
  end

  assign o_rd_hit        = w_hit;
  assign o_rd_data       = w_data;
  assign o_rd_level      = w_level;
  assign o_multi_hit_err = r_err;

endmodule
